// File: rtl/chacha_pkg.sv
// Shared constants, state encoding and helpers for the ChaCha quarter-round engine.
package chacha_pkg;

    localparam int unsigned ROT0 = 16;
    localparam int unsigned ROT1 = 12;
    localparam int unsigned ROT2 = 8;
    localparam int unsigned ROT3 = 7;

    localparam int ADDR_WORD_HI = 3;
    localparam int ADDR_WORD_LO = 2;
    localparam int ADDR_LANE_HI = 1;
    localparam int ADDR_LANE_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FF   = 2'd2
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr_step.sv
// One ARX step of the ChaCha quarter-round; the step index picks which quarter of the round runs.
module chacha_qr_step
    import chacha_pkg::*;
(
    input  logic [1:0]  step_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    always_comb begin
        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        d_o = d_i;
        case (step_i)
            2'd0: begin
                a_o = a_i + b_i;
                d_o = rotl32(d_i ^ a_o, ROT0);
            end
            2'd1: begin
                c_o = c_i + d_i;
                b_o = rotl32(b_i ^ c_o, ROT1);
            end
            2'd2: begin
                a_o = a_i + b_i;
                d_o = rotl32(d_i ^ a_o, ROT2);
            end
            default: begin
                c_o = c_i + d_i;
                b_o = rotl32(b_i ^ c_o, ROT3);
            end
        endcase
    end

endmodule

// File: rtl/chacha_qr_engine.sv
// Iterating ChaCha quarter-round engine behind a byte-serial load/readback port.
module chacha_qr_engine
    import chacha_pkg::*;
#(
    parameter int COUNT_W     = 8,
    parameter bit FEEDFORWARD = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         data_in,
    input  logic [3:0]         addr,
    input  logic               wr_en,
    input  logic               start,
    input  logic [COUNT_W-1:0] cfg_iters,
    input  logic               ff_en,
    output logic [7:0]         data_out,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [31:0]        w_q [4];
    logic [31:0]        w_d [4];
    logic [31:0]        s_q [4];
    logic [31:0]        step_w [4];
    logic [1:0]         step_q, step_d;
    logic [COUNT_W-1:0] iter_q, iter_d;
    logic               ff_q, ff_d;
    logic               done_q, done_d;
    logic               snap_load;
    logic [7:0]         dout_q;
    logic [1:0]         wsel, lsel;
    logic [31:0]        wr_word;

    assign wsel = addr[ADDR_WORD_HI:ADDR_WORD_LO];
    assign lsel = addr[ADDR_LANE_HI:ADDR_LANE_LO];

    always_comb begin
        wr_word = w_q[wsel];
        wr_word[{lsel, 3'b000} +: 8] = data_in;
    end

    chacha_qr_step u_step (
        .step_i (step_q),
        .a_i    (w_q[0]),
        .b_i    (w_q[1]),
        .c_i    (w_q[2]),
        .d_i    (w_q[3]),
        .a_o    (step_w[0]),
        .b_o    (step_w[1]),
        .c_o    (step_w[2]),
        .d_o    (step_w[3])
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        iter_d    = iter_q;
        ff_d      = ff_q;
        done_d    = 1'b0;
        snap_load = 1'b0;
        for (int i = 0; i < 4; i++) w_d[i] = w_q[i];
        case (state_q)
            IDLE: begin
                // The write is merged before the snapshot so a same-cycle start sees it.
                if (wr_en) w_d[wsel] = wr_word;
                if (start) begin
                    iter_d    = cfg_iters;
                    ff_d      = FEEDFORWARD && ff_en;
                    step_d    = 2'd0;
                    snap_load = 1'b1;
                    if (cfg_iters != '0) state_d = RUN;
                    else if (ff_d)       state_d = FF;
                    else                 done_d  = 1'b1;
                end
            end
            RUN: begin
                for (int i = 0; i < 4; i++) w_d[i] = step_w[i];
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    iter_d = iter_q - COUNT_W'(1);
                    if (iter_d == '0) begin
                        state_d = ff_q ? FF : IDLE;
                        done_d  = !ff_q;
                    end
                end
            end
            FF: begin
                for (int i = 0; i < 4; i++) w_d[i] = w_q[i] + s_q[i];
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            iter_q  <= '0;
            ff_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            iter_q  <= iter_d;
            ff_q    <= ff_d;
            done_q  <= done_d;
            dout_q  <= w_q[wsel][{lsel, 3'b000} +: 8];
            for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
        end
    end

    generate
        if (FEEDFORWARD) begin : g_snap
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < 4; i++) s_q[i] <= '0;
                end else if (snap_load) begin
                    for (int i = 0; i < 4; i++) s_q[i] <= w_d[i];
                end
            end
        end else begin : g_no_snap
            always_comb begin
                for (int i = 0; i < 4; i++) s_q[i] = '0;
            end
        end
    endgenerate

    assign data_out = dout_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_chacha_qr_engine.sv
// Self-checking bench for chacha_qr_engine against a whole-quarter-round reference model.
module tb_chacha_qr_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [3:0] addr;
    logic       wr_en;
    logic       start;
    logic [7:0] cfg_iters;
    logic       ff_en;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [4];

    chacha_qr_engine #(.COUNT_W(8), .FEEDFORWARD(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .addr      (addr),
        .wr_en     (wr_en),
        .start     (start),
        .cfg_iters (cfg_iters),
        .ff_en     (ff_en),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void model_run(input int n, input bit ff);
        logic [31:0] a, b, c, d;
        a = mdl[0]; b = mdl[1]; c = mdl[2]; d = mdl[3];
        for (int it = 0; it < n; it++) begin
            a = a + b; d = rl(d ^ a, 16);
            c = c + d; b = rl(b ^ c, 12);
            a = a + b; d = rl(d ^ a, 8);
            c = c + d; b = rl(b ^ c, 7);
        end
        if (ff) begin
            a = a + mdl[0]; b = b + mdl[1]; c = c + mdl[2]; d = d + mdl[3];
        end
        mdl[0] = a; mdl[1] = b; mdl[2] = c; mdl[3] = d;
    endfunction

    task automatic write_byte(input logic [3:0] ad, input logic [7:0] dv);
        @(negedge clk);
        addr = ad; data_in = dv; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) write_byte(4'(i * 4 + j), w[i][j*8 +: 8]);
            mdl[i] = w[i];
        end
    endtask

    task automatic read_byte(input logic [3:0] ad, output logic [7:0] v);
        @(negedge clk);
        addr = ad;
        @(negedge clk);
        v = data_out;
    endtask

    task automatic read_word(input int idx, output logic [31:0] v);
        logic [7:0] bt;
        for (int j = 0; j < 4; j++) begin
            read_byte(4'(idx * 4 + j), bt);
            v[j*8 +: 8] = bt;
        end
    endtask

    // Pulses start and watches until done; done_k is the sample index (1 = cycle after the start edge).
    task automatic run_and_watch(input int n, input bit ff, input bit at_now,
                                 output int busy_cnt, output int done_k);
        if (!at_now) @(negedge clk);
        cfg_iters = 8'(n); ff_en = ff; start = 1'b1;
        busy_cnt = 0; done_k = -1;
        for (int k = 1; k <= 4 * n + 20; k++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic check_words(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            read_word(i, v);
            n_checks++;
            if (v !== mdl[i]) begin
                n_fail++;
                $display("FAIL %s word%0d: got %h expected %h", tag, i, v, mdl[i]);
            end
        end
    endtask

    task automatic check_timing(input string tag, input int bc, input int dk,
                                input int exp_bc, input int exp_dk);
        n_checks++;
        if (bc !== exp_bc) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d expected %0d", tag, bc, exp_bc);
        end
        n_checks++;
        if (dk !== exp_dk) begin
            n_fail++;
            $display("FAIL %s done sample: got %0d expected %0d", tag, dk, exp_dk);
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset outputs: got busy=%b done=%b dout=%h expected 0 0 00", busy, done, data_out);
        end
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        check_words("reset");
    endtask

    task automatic test_byte_lanes;
        logic [7:0] bt;
        logic [31:0] v;
        for (int j = 0; j < 4; j++) write_byte(4'(4 + j), 8'(8'hA1 + j));
        for (int j = 0; j < 4; j++) begin
            read_byte(4'(4 + j), bt);
            n_checks++;
            if (bt !== 8'(8'hA1 + j)) begin
                n_fail++;
                $display("FAIL lane addr%0d: got %h expected %h", 4 + j, bt, 8'(8'hA1 + j));
            end
        end
        read_word(1, v);
        n_checks++;
        if (v !== 32'hA4A3A2A1) begin
            n_fail++;
            $display("FAIL lane word b: got %h expected a4a3a2a1", v);
        end
    endtask

    task automatic test_rfc(input bit ff);
        int bc, dk;
        logic [31:0] v;
        logic [31:0] exp_w [4];
        load_words(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
        if (ff) begin
            exp_w[0] = 32'hfb3ba405; exp_w[1] = 32'hcc1efbd2;
            exp_w[2] = 32'he10eb671; exp_w[3] = 32'h59a50a22;
        end else begin
            exp_w[0] = 32'hea2a92f4; exp_w[1] = 32'hcb1cf8ce;
            exp_w[2] = 32'h4581472e; exp_w[3] = 32'h5881c4bb;
        end
        run_and_watch(1, ff, 1'b0, bc, dk);
        check_timing(ff ? "rfc_ff" : "rfc", bc, dk, ff ? 5 : 4, ff ? 6 : 5);
        for (int i = 0; i < 4; i++) begin
            read_word(i, v);
            n_checks++;
            if (v !== exp_w[i]) begin
                n_fail++;
                $display("FAIL rfc ff=%0d word%0d: got %h expected %h", ff, i, v, exp_w[i]);
            end
        end
    endtask

    task automatic test_zero_iters;
        int bc, dk;
        load_words(32'h12345678, 32'h9abcdef0, 32'h0badf00d, 32'hdeadbeef);
        run_and_watch(0, 1'b0, 1'b0, bc, dk);
        check_timing("zero_noff", bc, dk, 0, 1);
        check_words("zero_noff");
        load_words(32'h80000001, 32'h00000003, 32'hffffffff, 32'h7fffffff);
        run_and_watch(0, 1'b1, 1'b0, bc, dk);
        model_run(0, 1'b1);
        check_timing("zero_ff", bc, dk, 1, 2);
        check_words("zero_ff");
        // write and start in the same cycle: snapshot must include the new byte
        @(negedge clk);
        addr = 4'd0; data_in = 8'h55; wr_en = 1'b1;
        mdl[0][7:0] = 8'h55;
        run_and_watch(0, 1'b1, 1'b1, bc, dk);
        model_run(0, 1'b1);
        check_timing("wr_start", bc, dk, 1, 2);
        check_words("wr_start");
    endtask

    task automatic test_busy_ignore;
        int bc, dk;
        logic [31:0] a_seq [4];
        logic [31:0] a0, b0, c0, d0, d1, c1, b1;
        load_words(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
        a0 = mdl[0]; b0 = mdl[1]; c0 = mdl[2]; d0 = mdl[3];
        a_seq[0] = a0;
        a_seq[1] = a0 + b0;
        a_seq[2] = a_seq[1];
        d1 = rl(d0 ^ a_seq[1], 16);
        c1 = c0 + d1;
        b1 = rl(b0 ^ c1, 12);
        a_seq[3] = a_seq[2] + b1;
        @(negedge clk);
        cfg_iters = 8'd2; ff_en = 1'b0; start = 1'b1;
        bc = 0; dk = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (busy) bc++;
            if (done) begin
                dk = k;
                break;
            end
            if (k >= 2 && k <= 5) begin
                n_checks++;
                if (data_out !== a_seq[k-2][(k-2)*8 +: 8]) begin
                    n_fail++;
                    $display("FAIL live readback k=%0d: got %h expected %h", k, data_out, a_seq[k-2][(k-2)*8 +: 8]);
                end
            end
            if (k == 1) begin
                data_in = 8'hFF; wr_en = 1'b1; start = 1'b1; cfg_iters = 8'd5; ff_en = 1'b1;
            end
            if (k <= 4) addr = 4'(k - 1);
        end
        model_run(2, 1'b0);
        check_timing("busy_ignore", bc, dk, 8, 9);
        check_words("busy_ignore");
    endtask

    task automatic test_abort;
        int bc, dk, late_busy;
        logic [7:0] bt;
        load_words(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
        @(negedge clk);
        cfg_iters = 8'd3; ff_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dk = -1; late_busy = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dk = k;
            if (busy) late_busy++;
            @(negedge clk);
        end
        n_checks++;
        if (dk !== -1 || late_busy !== 0) begin
            n_fail++;
            $display("FAIL abort: got done_at=%0d busy_cycles=%0d expected -1 0", dk, late_busy);
        end
        for (int i = 0; i < 16; i++) begin
            read_byte(4'(i), bt);
            n_checks++;
            if (bt !== 8'h00) begin
                n_fail++;
                $display("FAIL abort readback addr%0d: got %h expected 00", i, bt);
            end
        end
        for (int i = 0; i < 4; i++) mdl[i] = '0;
    endtask

    task automatic test_random;
        int bc, dk, n;
        bit ff;
        for (int r = 0; r < 6; r++) begin
            load_words($urandom, $urandom, $urandom, $urandom);
            n  = $urandom_range(0, 5);
            ff = 1'($urandom_range(0, 1));
            run_and_watch(n, ff, 1'b0, bc, dk);
            model_run(n, ff);
            check_timing("random", bc, dk, 4 * n + int'(ff), 4 * n + int'(ff) + 1);
            check_words("random");
        end
    endtask

    task automatic test_back_to_back;
        int bc, dk;
        load_words($urandom, $urandom, $urandom, $urandom);
        run_and_watch(1, 1'b0, 1'b0, bc, dk);
        model_run(1, 1'b0);
        check_timing("b2b_first", bc, dk, 4, 5);
        run_and_watch(2, 1'b1, 1'b1, bc, dk);
        model_run(2, 1'b1);
        check_timing("b2b_second", bc, dk, 9, 10);
        check_words("b2b");
    endtask

    initial begin
        rst_n = 1'b0; data_in = '0; addr = '0; wr_en = 1'b0;
        start = 1'b0; cfg_iters = '0; ff_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_byte_lanes();
        test_rfc(1'b0);
        test_rfc(1'b1);
        test_zero_iters();
        test_busy_ignore();
        test_abort();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chacha_qr_engine.md
# chacha_qr_engine

Iterating ChaCha quarter-round engine with a byte-wide load/readback port. Four 32-bit state words (a, b, c, d) are loaded byte by byte. On `start`, the engine applies the ChaCha quarter-round a programmable number of times, one ARX step per cycle. An optional feed-forward adds the original input back into the result. It replaces the plain register file as the compute core behind the byte-serial pin interface.

## Interface
- `COUNT_W`, default 8: width of the iteration-count input; maximum iterations is 2^COUNT_W−1.
- `FEEDFORWARD`, default 1: 1 instantiates the snapshot registers and the FF state; 0 removes them, and `ff_en` is then ignored.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  8  write byte.
- `addr`  in  4  byte address. `[3:2]` selects the word (0=a, 1=b, 2=c, 3=d). `[1:0]` selects the byte lane (0 = bits 7:0 … 3 = bits 31:24).
- `wr_en`  in  1  write `data_in` to the addressed byte.
- `start`  in  1  begin a run (single-cycle request).
- `cfg_iters`  in  COUNT_W  number of quarter-rounds; sampled on accepted `start`.
- `ff_en`  in  1  enable feed-forward add; sampled on accepted `start`.
- `data_out`  out  8  registered readback of the addressed byte.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when results are final.

## Operation
- State machine: IDLE → RUN → (FF) → IDLE.
- **IDLE**
  - `wr_en` updates the addressed byte only.
  - `start` is accepted in IDLE only. On acceptance:
    - latch `cfg_iters` into the iteration counter;
    - latch `ff_en`;
    - copy a–d into the snapshot registers `sa`–`sd`.
  - If the latched count is 0:
    - with FF enabled, go to FF;
    - otherwise, pulse `done` next cycle and stay in IDLE.
- **RUN**
  - A 2-bit step counter cycles 0..3. One step executes per cycle; all arithmetic is mod 2^32, and `<<<` is 32-bit rotate-left.
    - step 0: a+=b; d^=a; d<<<=16
    - step 1: c+=d; b^=c; b<<<=12
    - step 2: a+=b; d^=a; d<<<=8
    - step 3: c+=d; b^=c; b<<<=7
  - After step 3, decrement the iteration counter.
  - When the counter reaches 0, go to FF if FF is latched, else go to IDLE.
- **FF** (one cycle): a+=sa, b+=sb, c+=sc, d+=sd. Then go to IDLE.
- Writes (`wr_en`) and `start` received while `busy` is high are ignored and dropped. Nothing is queued.
- If `wr_en` and `start` are asserted in the same IDLE cycle, the write lands first and the snapshot/run uses the updated word.
- Readback is always live: the byte reads the current register value, including intermediate values during RUN.

## Timing
- Reset values: a–d, sa–sd, counters = 0; state IDLE; `data_out`=0, `busy`=0, `done`=0.
- `data_out` latency: 1 cycle from `addr` (registered).
- `start` is sampled at edge E0. `busy` is high from E0+1 for 4·N cycles, plus 1 if FF.
- `done` is high for exactly the first cycle in which `busy` is low again. Results are readable from that cycle onward.
- N=0 with FF off: `busy` never rises, and `done` pulses at E0+1.
- A new `start` is accepted in the same cycle that `done` is high.
- `rst_n` low mid-run aborts the run at the next edge:
  - all state is cleared;
  - `done` does not pulse.

## Structure
- Package `chacha_pkg` contains:
  - rotation constants `ROT0..ROT3` = 16, 12, 8, 7;
  - the FSM state enum (IDLE, RUN, FF);
  - word/lane address field localparams.
- Sub-module `chacha_qr_step` is combinational. Given the 2-bit step index and a–d, it returns the next a–d. The top level holds the registers, FSM, counters, snapshot and byte port.

## Test plan
- RFC 7539 §2.1.1 vector. Load a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567; start with N=1, ff_en=0.
  - Required: `done` 4 cycles after `busy` rises.
  - Required result: a=0xea2a92f4, b=0xcb1cf8ce, c=0x4581472e, d=0x5881c4bb.
- Same load with ff_en=1. Required: each word equals (RFC result + input) mod 2^32, e.g. a=0xfb3ba405. `busy` is high for 5 cycles.
- N=0 cases:
  - ff_en=0: `done` at E0+1, no `busy`, words unchanged.
  - ff_en=1, a=0x80000001: a reads 0x00000002 after done.
- Run with N=2. During RUN:
  - write 0xFF to addr 0 → ignored;
  - pulse `start` → ignored;
  - `done` appears only after 8 cycles;
  - readback of addr 0..3 shows intermediate a.
- Assert `rst_n` low at cycle 3 of a run.
  - Required: all readback = 0x00, `busy`=0.
  - Required: no `done` pulse.
- Byte lanes: write 0xA1..0xA4 to addr 4..7. Read addr 4..7 with 1-cycle latency. Required: b=0xA4A3A2A1.
